// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle carry-lookahead adder/subtractor, one CHUNK slice per clock
module cla_seq_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rslt,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int NG     = CHUNK / 4;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  opa, opb, part, next_part;
   logic              carry;
   logic [KW-1:0]     k;
   logic              last;

   logic [CHUNK-1:0]  sa, sb, sp, sg, sc, ssum;
   logic [NG-1:0]     gp, gg;
   logic [NG:0]       gc;
   logic              term;

   assign last = (k == KW'(NCHUNK - 1));

   // State register; reset wins over every handshake
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and the combinational accept handshake
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN:  if (last) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slice adder: 4-bit groups with PP/GG, flattened second-level lookahead across groups
   always_comb begin
      sa = opa[k*CHUNK +: CHUNK];
      sb = opb[k*CHUNK +: CHUNK];
      sp = sa | sb;
      sg = sa & sb;
      term = 1'b0;
      for (int j = 0; j < NG; j++) begin
         gp[j] = &sp[4*j +: 4];
         gg[j] = sg[4*j+3]
               | (sp[4*j+3] & sg[4*j+2])
               | (sp[4*j+3] & sp[4*j+2] & sg[4*j+1])
               | (sp[4*j+3] & sp[4*j+2] & sp[4*j+1] & sg[4*j]);
      end
      gc[0] = carry;
      for (int j = 1; j <= NG; j++) begin
         term = carry;
         for (int m = 0; m < j; m++) term = term & gp[m];
         gc[j] = term;
         for (int i = 0; i < j; i++) begin
            term = gg[i];
            for (int m = i + 1; m < j; m++) term = term & gp[m];
            gc[j] = gc[j] | term;
         end
      end
      for (int j = 0; j < NG; j++) begin
         sc[4*j]   = gc[j];
         sc[4*j+1] = sg[4*j] | (sp[4*j] & gc[j]);
         sc[4*j+2] = sg[4*j+1] | (sp[4*j+1] & sg[4*j]) | (sp[4*j+1] & sp[4*j] & gc[j]);
         sc[4*j+3] = sg[4*j+2] | (sp[4*j+2] & sg[4*j+1]) | (sp[4*j+2] & sp[4*j+1] & sg[4*j])
                   | (sp[4*j+2] & sp[4*j+1] & sp[4*j] & gc[j]);
      end
      ssum = sa ^ sb ^ sc;
      next_part = part;
      next_part[k*CHUNK +: CHUNK] = ssum;
   end

   // Datapath: operand capture, per-slice accumulation, result registers loaded only on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         opa       <= '0;
         opb       <= '0;
         part      <= '0;
         carry     <= 1'b0;
         k         <= '0;
         rslt      <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa   <= A;
                  opb   <= sub ? ~B : B;
                  carry <= sub ? 1'b1 : Cin;
                  k     <= '0;
               end
            end
            RUN: begin
               part  <= next_part;
               carry <= gc[NG];
               k     <= k + 1'b1;
               if (last) begin
                  rslt      <= next_part;
                  cout      <= gc[NG];
                  ovf       <= sc[CHUNK-1] ^ gc[NG];
                  out_valid <= 1'b1;
                  k         <= '0;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - directed self-checking bench for cla_seq_adder
module tb_cla_seq_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, sub, Cin, out_valid, out_ready, cout, ovf;
   logic [63:0] A, B, rslt;

   logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16, cout16, ovf16;
   logic [15:0] a16, b16, rslt16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cla_seq_adder #(.WIDTH(64), .CHUNK(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .sub(sub), .Cin(Cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .rslt(rslt), .cout(cout), .ovf(ovf)
   );

   cla_seq_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .A(a16), .B(b16), .sub(sub16), .Cin(cin16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .rslt(rslt16), .cout(cout16), .ovf(ovf16)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        s;
      logic        ci;
      logic [63:0] er;
      logic        ec;
      logic        eo;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one op, scramble inputs after accept, wait for out_valid, then pop the result
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic ci,
                         output logic [63:0] r, output logic c, output logic o, output int lat);
      @(negedge clk);
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      in_valid = 1'b1; A = a; B = b; sub = s; Cin = ci;
      @(posedge clk); #1;
      in_valid = 1'b0; A = ~a; B = ~b; sub = ~s; Cin = ~ci;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      r = rslt; c = cout; o = ovf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [63:0] r;
   logic        c, o;
   int          lat;

   initial begin
      vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[3] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{64'd3, 64'd4, 1'b0, 1'b1, 64'd8, 1'b0, 1'b0};
      vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                  64'h2222_2222_2222_2211, 1'b0, 1'b0};
      vecs[7] = '{64'hDEAD_BEEF_0000_1111, 64'hDEAD_BEEF_0000_1111, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
      vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; sub = 1'b0; Cin = 1'b0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; cin16 = 1'b0;

      // Reset held two cycles
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_rslt", rslt, 64'd0);
      chk("reset_cout", 64'(cout), 64'd0);
      chk("reset_ovf", 64'(ovf), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_reset", 64'(in_ready), 64'd1);

      // Directed vector table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ci, r, c, o, lat);
         chk($sformatf("vec%0d_rslt", i), r, vecs[i].er);
         chk($sformatf("vec%0d_cout", i), 64'(c), 64'(vecs[i].ec));
         chk($sformatf("vec%0d_ovf", i), 64'(o), 64'(vecs[i].eo));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      end
      chk("rslt_held_in_idle", rslt, vecs[8].er);

      // Backpressure with a competing request held on the input
      @(negedge clk);
      in_valid = 1'b1; A = 64'd1; B = 64'd2; sub = 1'b0; Cin = 1'b0;
      @(posedge clk); #1;
      A = 64'd10; B = 64'd20;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      chk("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid_held", 64'(out_valid), 64'd1);
         chk("bp_rslt_held", rslt, 64'd3);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_accept", 64'(in_ready), 64'd0);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      chk("bp_second_latency", 64'(lat), 64'd4);
      chk("bp_second_rslt", rslt, 64'd30);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset on the second RUN edge discards the op
      @(negedge clk);
      in_valid = 1'b1; A = 64'hFFFF; B = 64'h1; sub = 1'b0; Cin = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_rslt_cleared", rslt, 64'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
         end
         chk("midrst_no_out_valid", 64'(seen), 64'd0);
      end
      run_op(64'd3, 64'd4, 1'b0, 1'b0, r, c, o, lat);
      chk("midrst_next_rslt", r, 64'd7);
      chk("midrst_next_latency", 64'(lat), 64'd4);

      // Single-slice instance: one RUN cycle
      @(negedge clk);
      in_valid16 = 1'b1; a16 = 16'd3; b16 = 16'd4;
      @(posedge clk); #1;
      in_valid16 = 1'b0; a16 = 16'hFFFF;
      @(posedge clk); #1;
      chk("w16_out_valid_1cyc", 64'(out_valid16), 64'd1);
      chk("w16_rslt", 64'(rslt16), 64'd7);
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
      @(negedge clk);
      in_valid16 = 1'b1; a16 = 16'h7FFF; b16 = 16'h0001;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      @(posedge clk); #1;
      chk("w16_ovf_out_valid", 64'(out_valid16), 64'd1);
      chk("w16_ovf_rslt", 64'(rslt16), 64'h8000);
      chk("w16_ovf_flag", 64'(ovf16), 64'd1);
      chk("w16_ovf_cout", 64'(cout16), 64'd0);
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
Parametrised, multi-cycle carry-lookahead adder/subtractor. It processes a WIDTH-bit operation one CHUNK-bit slice per clock.
- Inside each slice: 4-bit lookahead groups with group P/G, plus a second-level lookahead across the groups.
- Between slices: carry is held in a register.
- Handshakes: valid/ready on both the input and the output.
- Adds subtract mode and a signed-overflow flag.
It is the wide-operand successor to the team's single-cycle 16-bit CLA and is used where WIDTH-bit sums are too deep for one cycle.

Parameters:
- WIDTH, 64, operand/result width. Must be a multiple of CHUNK.
- CHUNK, 16, bits added per cycle. Must be a multiple of 4 and ≤ 64.
- NCHUNK, WIDTH/CHUNK, derived (localparam). Number of RUN cycles.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- sub  in  1  1 = A - B, 0 = A + B + Cin
- Cin  in  1  carry-in for add; ignored when sub=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- rslt  out  WIDTH  sum/difference
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Reset: rst sampled high at an edge causes:
  - state=IDLE
  - out_valid=0, rslt=0, cout=0, ovf=0
  - internal operand, partial-result, carry and chunk-index registers cleared
  - in_ready=1 in the first cycle after reset deasserts
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE), combinational from state.
  - out_valid = (state==DONE), registered.
- IDLE:
  - Accept on the edge where in_valid && in_ready.
  - Latch A and B' = sub ? ~B : B.
  - Carry register = sub ? 1 : Cin.
  - Chunk index k = 0.
  - Go to RUN.
- RUN: each edge computes slice k.
  - sum_k = A[k] + B'[k] + carry.
  - sum_k is written into the partial-result slice k; carry register takes the slice carry-out; k increments.
  - On the slice k = NCHUNK-1 edge:
    - load rslt with the full partial result (including the final slice);
    - cout = final carry;
    - ovf = carry into MSB XOR carry out of MSB;
    - go to DONE.
- Latency: out_valid is high in the NCHUNK-th cycle after the accept edge (NCHUNK RUN edges). The minimum for NCHUNK=1 is 1 cycle.
- DONE:
  - rslt, cout and ovf are held stable while out_valid=1 && out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid falls.
  - in_ready is 0 in DONE, so there is no same-cycle turnaround. The next accept is at the earliest on the edge after returning to IDLE.
- Output registers: rslt, cout and ovf change only when entering DONE or on reset. They keep the last result through IDLE and RUN.
- in_valid while busy (RUN/DONE) is ignored. Changes on A/B/sub/Cin after accept have no effect.
- Wrap-around: result is modulo 2^WIDTH; overflow is reported via cout/ovf only.
- Reset mid-operation (RUN or DONE): the operation is discarded and no out_valid pulse is produced. Next cycle: IDLE with in_ready=1.
- rst has priority over all handshakes in the same cycle.
- Slice lookahead: per-bit P=A|B, G=A&B; 4-bit group PP/GG; second-level carries across CHUNK/4 groups. No ripple chains longer than 4 bits.

Test Plan (WIDTH=64, CHUNK=16 unless noted):
1. Reset: hold rst 2 cycles, then release.
   - During reset: out_valid=0, rslt=0, cout=0, ovf=0.
   - First cycle after release: in_ready=1.
2. Cross-slice carry: A=64'h0000_0000_FFFF_FFFF, B=1, sub=0, Cin=0.
   - rslt=64'h0000_0001_0000_0000, cout=0, ovf=0.
   - out_valid exactly 4 cycles after accept.
3. Full wrap / signed overflow (add):
   - A=all-ones, B=0, Cin=1 → rslt=0, cout=1, ovf=0.
   - A=64'h7FFF_FFFF_FFFF_FFFF, B=1 → rslt=64'h8000_0000_0000_0000, cout=0, ovf=1.
4. Subtract:
   - A=5, B=7, sub=1, Cin=1 (ignored) → rslt=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
   - A=64'h8000_0000_0000_0000, B=1, sub=1 → rslt=64'h7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
   - rslt/cout/ovf stable; in_ready=0; the new operands are not taken.
   - After out_ready=1: IDLE next cycle; the new op is accepted the following edge and gives the correct result.
6. Reset mid-op: assert rst on the 2nd RUN edge.
   - No out_valid for that op; in_ready=1 next cycle.
   - Following op A=3, B=4 → rslt=7.
   - With WIDTH=16, CHUNK=16: same add completes with out_valid 1 cycle after accept.
